// File: rtl/sfp_port_ctrl.sv
// sfp_port_ctrl: per-port SFP cage manager (tx_disable sequencing, TX_FAULT recovery, RX_LOS debounce, status LED)
//   clk_i              system clock
//   resetn_i           synchronous active-low reset
//   port_en_i          per-port software enable (level)
//   clear_fault_i      per-port 1-cycle pulse releasing a port from LOCKOUT
//   sfp_tx_fault_i     cage TX_FAULT pins (async)
//   sfp_rx_loss_i      cage RX_LOS pins (async)
//   sfp_tx_disable_o   cage TX_DISABLE (1 = laser off)
//   link_ok_o          port in RUN with LOS clear and no fault
//   fault_latched_o    port in LOCKOUT
//   port_state_o       FSM state, port i at [3i+2:3i]
//   led_o              status LED
module sfp_port_ctrl #(
    parameter int NUM_PORTS   = 2,
    parameter int T_INIT_CYC  = 30000000,
    parameter int T_RESET_CYC = 1000,
    parameter int DEB_CYC     = 100000,
    parameter int MAX_RETRY   = 3,
    parameter int BLINK_CYC   = 25000000
) (
    input  logic                   clk_i,
    input  logic                   resetn_i,
    input  logic [NUM_PORTS-1:0]   port_en_i,
    input  logic [NUM_PORTS-1:0]   clear_fault_i,
    input  logic [NUM_PORTS-1:0]   sfp_tx_fault_i,
    input  logic [NUM_PORTS-1:0]   sfp_rx_loss_i,
    output logic [NUM_PORTS-1:0]   sfp_tx_disable_o,
    output logic [NUM_PORTS-1:0]   link_ok_o,
    output logic [NUM_PORTS-1:0]   fault_latched_o,
    output logic [3*NUM_PORTS-1:0] port_state_o,
    output logic                   led_o
);
    localparam int TW = $clog2((T_INIT_CYC > T_RESET_CYC ? T_INIT_CYC : T_RESET_CYC) + 1);
    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam int DW = $clog2(DEB_CYC + 1);
    localparam int BW = $clog2(BLINK_CYC + 1);
    localparam logic [TW-1:0] TMR_MAX  = {TW{1'b1}};
    localparam logic [TW-1:0] INIT_END = TW'(T_INIT_CYC - 1);
    localparam logic [TW-1:0] RST_END  = TW'(T_RESET_CYC - 1);
    localparam logic [DW-1:0] DEB_END  = DW'(DEB_CYC - 1);
    localparam logic [BW-1:0] BLK_END  = BW'(BLINK_CYC - 1);
    typedef enum logic [2:0] {DISABLED, INIT, RUN, FAULT_RST, FAULT_WAIT, LOCKOUT} state_t;
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        state_t          state_q, state_d;
        logic [TW-1:0]   tmr_q, tmr_d;
        logic [RW-1:0]   rty_q, rty_d;
        logic [DW-1:0]   deb_q, deb_d;
        logic            los_q, los_d;
        logic            fault_m_q, fault_s_q, los_m_q, los_s_q;
        logic            tx_dis_q, link_q, lock_q;
        always_comb begin
            state_d = state_q;
            tmr_d   = (tmr_q == TMR_MAX) ? tmr_q : tmr_q + 1'b1;
            rty_d   = rty_q;
            case (state_q)
                DISABLED: begin
                    tmr_d = '0;
                    rty_d = '0;
                    state_d = INIT;
                end
                INIT: if (tmr_q == INIT_END) begin
                    state_d = RUN;
                    tmr_d   = '0;
                end
                RUN: begin
                    tmr_d = '0;
                    rty_d = '0;
                    if (fault_s_q) begin
                        state_d = FAULT_RST;
                        rty_d   = RW'(1);
                    end
                end
                FAULT_RST: if (tmr_q == RST_END) begin
                    state_d = FAULT_WAIT;
                    tmr_d   = '0;
                end
                FAULT_WAIT: if (tmr_q == INIT_END) begin
                    tmr_d   = '0;
                    state_d = !fault_s_q ? RUN : (rty_q < RW'(MAX_RETRY)) ? FAULT_RST : LOCKOUT;
                    rty_d   = (fault_s_q && rty_q < RW'(MAX_RETRY)) ? rty_q + 1'b1 : rty_q;
                end
                LOCKOUT: begin
                    tmr_d = '0;
                    if (clear_fault_i[p]) begin
                        state_d = INIT;
                        rty_d   = '0;
                    end
                end
                default: state_d = DISABLED;
            endcase
            // Disable wins over every other event, including clear_fault.
            if (!port_en_i[p]) begin
                state_d = DISABLED;
                tmr_d   = '0;
                rty_d   = '0;
            end
        end
        // Debounced LOS follows the synchronised pin only after DEB_CYC consecutive differing cycles.
        always_comb begin
            deb_d = (los_s_q == los_q || deb_q == DEB_END) ? '0 : deb_q + 1'b1;
            los_d = (los_s_q != los_q && deb_q == DEB_END) ? los_s_q : los_q;
        end
        always_ff @(posedge clk_i) begin
            if (!resetn_i) begin
                state_q   <= DISABLED;
                tmr_q     <= '0;
                rty_q     <= '0;
                deb_q     <= '0;
                los_q     <= 1'b1;
                fault_m_q <= 1'b0;
                fault_s_q <= 1'b0;
                los_m_q   <= 1'b0;
                los_s_q   <= 1'b0;
                tx_dis_q  <= 1'b1;
                link_q    <= 1'b0;
                lock_q    <= 1'b0;
            end else begin
                state_q   <= state_d;
                tmr_q     <= tmr_d;
                rty_q     <= rty_d;
                deb_q     <= deb_d;
                los_q     <= los_d;
                fault_m_q <= sfp_tx_fault_i[p];
                fault_s_q <= fault_m_q;
                los_m_q   <= sfp_rx_loss_i[p];
                los_s_q   <= los_m_q;
                tx_dis_q  <= !(state_d == RUN || state_d == FAULT_WAIT);
                link_q    <= state_q == RUN && !los_q && !fault_s_q;
                lock_q    <= state_d == LOCKOUT;
            end
        end
        assign sfp_tx_disable_o[p]   = tx_dis_q;
        assign link_ok_o[p]          = link_q;
        assign fault_latched_o[p]    = lock_q;
        assign port_state_o[3*p+:3]  = state_q;
    end
    logic [BW-1:0] blink_q, blink_d;
    logic          led_q, led_d, any_lock;
    always_comb begin
        any_lock = |fault_latched_o;
        blink_d  = (any_lock && blink_q != BLK_END) ? blink_q + 1'b1 : '0;
        led_d    = any_lock ? (blink_q == BLK_END ? !led_q : led_q)
                            : (|port_en_i && &(link_ok_o | ~port_en_i));
    end
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            blink_q <= '0;
            led_q   <= 1'b0;
        end else begin
            blink_q <= blink_d;
            led_q   <= led_d;
        end
    end
    assign led_o = led_q;
endmodule
